// File: rtl/traffic_light_fsm_if.sv
// Sensor/timer inputs and lamp/timer-start outputs of the intersection
// controller. master: sensor+timer side. slave: traffic_light_fsm.
//   TS, TL, C                : short/long interval expired, side car present
//   MR, MY, MG, SR, SY, SG   : main/side red, yellow, green lamps
//   ST                       : one-cycle timer restart strobe
interface traffic_light_fsm_if;
    logic TS;
    logic TL;
    logic C;
    logic MR;
    logic MY;
    logic MG;
    logic SR;
    logic SY;
    logic SG;
    logic ST;

    modport master (
        output TS, TL, C,
        input  MR, MY, MG, SR, SY, SG, ST
    );

    modport slave (
        input  TS, TL, C,
        output MR, MY, MG, SR, SY, SG, ST
    );
endinterface

// File: rtl/traffic_light_fsm.sv
// Main/side-street traffic light controller: Moore lamps, Mealy ST strobe.
// Ports: Clk, reset (sync, active-high), bus (traffic_light_fsm_if.slave).
// Optional macro TRAFFIC_ALL_RED_EN adds all-red clearance states AR1/AR2.
module traffic_light_fsm (
    input  logic                 Clk,
    input  logic                 reset,
    traffic_light_fsm_if.slave   bus
);

`ifdef TRAFFIC_ALL_RED_EN
    typedef enum logic [2:0] {
        S0  = 3'd0,
        S1  = 3'd1,
        S2  = 3'd2,
        S3  = 3'd3,
        AR1 = 3'd4,
        AR2 = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2,
        S3 = 2'd3
    } state_t;
`endif

    state_t r_state;
    state_t w_next;
    logic   w_go;
    logic   w_mr, w_my, w_mg;
    logic   w_sr, w_sy, w_sg;

    always_ff @(posedge Clk) begin
        if (reset)
            r_state <= S0;
        else
            r_state <= w_next;
    end

    // w_go is the current state's exit condition; it doubles as the
    // timer-restart request since every state change restarts the timer.
    always_comb begin
        w_go   = 1'b0;
        w_next = S0;
        case (r_state)
            S0: begin
                w_go   = bus.TL & bus.C;
                w_next = w_go ? S1 : S0;
            end
            S1: begin
                w_go   = bus.TS;
`ifdef TRAFFIC_ALL_RED_EN
                w_next = w_go ? AR1 : S1;
`else
                w_next = w_go ? S2 : S1;
`endif
            end
            S2: begin
                w_go   = bus.TL | ~bus.C;
                w_next = w_go ? S3 : S2;
            end
            S3: begin
                w_go   = bus.TS;
`ifdef TRAFFIC_ALL_RED_EN
                w_next = w_go ? AR2 : S3;
`else
                w_next = w_go ? S0 : S3;
`endif
            end
`ifdef TRAFFIC_ALL_RED_EN
            AR1: begin
                w_go   = bus.TS;
                w_next = w_go ? S2 : AR1;
            end
            AR2: begin
                w_go   = bus.TS;
                w_next = w_go ? S0 : AR2;
            end
`endif
            default: begin
                // illegal encoding: recover to S0 without a timer restart
                w_go   = 1'b0;
                w_next = S0;
            end
        endcase
    end

    // Lamps come only from the state register; illegal codes show all-red.
    always_comb begin
        w_mr = 1'b0;
        w_my = 1'b0;
        w_mg = 1'b0;
        w_sr = 1'b0;
        w_sy = 1'b0;
        w_sg = 1'b0;
        case (r_state)
            S0: begin
                w_mg = 1'b1;
                w_sr = 1'b1;
            end
            S1: begin
                w_my = 1'b1;
                w_sr = 1'b1;
            end
            S2: begin
                w_mr = 1'b1;
                w_sg = 1'b1;
            end
            S3: begin
                w_mr = 1'b1;
                w_sy = 1'b1;
            end
            default: begin
                w_mr = 1'b1;
                w_sr = 1'b1;
            end
        endcase
    end

    assign bus.ST = w_go & ~reset;
    assign bus.MR = w_mr;
    assign bus.MY = w_my;
    assign bus.MG = w_mg;
    assign bus.SR = w_sr;
    assign bus.SY = w_sy;
    assign bus.SG = w_sg;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Self-checking bench for traffic_light_fsm: phase-list reference model,
// directed scenarios with literal expectations, then random stimulus.
module tb_traffic_light_fsm;

    logic Clk;
    logic reset;

    traffic_light_fsm_if bus ();

    traffic_light_fsm dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Phase list in service order. Lamps packed {MR,MY,MG,SR,SY,SG}.
    // kind 0: leave on TL&C, kind 1: leave on TS, kind 2: leave on TL|~C.
`ifdef TRAFFIC_ALL_RED_EN
    localparam int NP = 6;
    logic [5:0] lamp_tab [NP] = '{6'b001100, 6'b010100, 6'b100100,
                                  6'b100001, 6'b100010, 6'b100100};
    int         kind_tab [NP] = '{0, 1, 1, 2, 1, 1};
`else
    localparam int NP = 4;
    logic [5:0] lamp_tab [NP] = '{6'b001100, 6'b010100,
                                  6'b100001, 6'b100010};
    int         kind_tab [NP] = '{0, 1, 2, 1};
`endif

    int   m_phase = 0;
    logic m_valid = 1'b0;

    function automatic logic leave(int ph, logic ts, logic tl, logic c);
        case (kind_tab[ph])
            0:       return tl & c;
            1:       return ts;
            default: return tl | ~c;
        endcase
    endfunction

    function automatic logic [5:0] lamps();
        return {bus.MR, bus.MY, bus.MG, bus.SR, bus.SY, bus.SG};
    endfunction

    task automatic chk(string name, logic [5:0] got, logic [5:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b at %0t",
                     name, got, exp, $time);
    endtask

    // Reference model advance
    always @(posedge Clk) begin
        if (reset) begin
            m_phase <= 0;
            m_valid <= 1'b1;
        end else if (m_valid &&
                     leave(m_phase, bus.TS, bus.TL, bus.C)) begin
            m_phase <= (m_phase + 1) % NP;
        end
    end

    // Cycle-by-cycle compare against the model
    always @(negedge Clk) begin
        if (m_valid) begin
            logic exp_st;
            logic [5:0] l;
            exp_st = !reset && leave(m_phase, bus.TS, bus.TL, bus.C);
            l = lamps();
            chk("model_lamps", l, lamp_tab[m_phase]);
            chk("model_st", {5'b0, bus.ST}, {5'b0, exp_st});
            chk("one_lamp_per_street",
                {4'b0, ($countones(l[5:3]) == 1),
                       ($countones(l[2:0]) == 1)}, 6'b000011);
        end
    end

    task automatic drive(logic r, logic ts, logic tl, logic c);
        reset  = r;
        bus.TS = ts;
        bus.TL = tl;
        bus.C  = c;
    endtask

    // finish the current cycle and land 1 time unit after the edge
    task automatic edge_();
        @(posedge Clk);
        #1;
    endtask

    task automatic st_is(string name, logic exp);
        #1;
        chk(name, {5'b0, bus.ST}, {5'b0, exp});
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #1;

        // Reset
        st_is("reset_st", 1'b0);
        chk("reset_lamps", lamps(), 6'b001100);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        st_is("reset_st_priority", 1'b0);
        edge_();
        chk("reset_forces_s0", lamps(), 6'b001100);

        // Yield
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        st_is("yield_st", 1'b1);
        edge_();
        chk("yield_lamps", lamps(), 6'b010100);

        // Reset mid-phase from main yellow
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        st_is("midreset_st", 1'b0);
        edge_();
        chk("midreset_lamps", lamps(), 6'b001100);

        // No car: timers expired but nobody waiting
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            st_is("nocar_st", 1'b0);
            edge_();
            chk("nocar_lamps", lamps(), 6'b001100);
        end

        // Full cycle
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        st_is("full_s0_st", 1'b1);
        edge_();
        chk("full_s1", lamps(), 6'b010100);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        st_is("full_s1_wait", 1'b0);
        edge_();
        chk("full_s1_hold", lamps(), 6'b010100);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        st_is("full_s1_st", 1'b1);
        edge_();
`ifdef TRAFFIC_ALL_RED_EN
        chk("ar1_all_red", lamps(), 6'b100100);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        st_is("ar1_wait", 1'b0);
        edge_();
        chk("ar1_hold", lamps(), 6'b100100);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        st_is("ar1_st", 1'b1);
        edge_();
`endif
        chk("full_s2", lamps(), 6'b100001);

        // Side green holds while cars keep coming
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            st_is("sg_hold_st", 1'b0);
            edge_();
            chk("sg_hold", lamps(), 6'b100001);
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        st_is("sg_clear_st", 1'b1);
        edge_();
        chk("full_s3", lamps(), 6'b100010);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        st_is("full_s3_st", 1'b1);
        edge_();
`ifdef TRAFFIC_ALL_RED_EN
        chk("ar2_all_red", lamps(), 6'b100100);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        st_is("ar2_st", 1'b1);
        edge_();
`endif
        chk("full_back_s0", lamps(), 6'b001100);

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 99) < 40),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 60));
            edge_();
        end

        // Continuous TS/TL with a car: one state per cycle
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        edge_();
        for (int i = 0; i < 2 * NP; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1);
            st_is("held_timers_st", 1'b1);
            edge_();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Moore-style controller for a main-street/side-street intersection, with a Mealy timer-start strobe. It gives the main street green by default. It yields to the side street only when a side-street car is waiting and the long timer has expired. Yellow phases are timed by an external interval timer that this block restarts through `ST` and reads back through `TS` (short interval) and `TL` (long interval). Sits between the car sensor / interval-timer block and the lamp drivers.

## Interface
- Parameters: none.
- Clocking: one clock `Clk`; reset `reset` is synchronous and active-high.
- `Clk`  in  1  rising-edge clock for all state.
- `reset`  in  1  synchronous active-high reset; overrides all other inputs.
- `TS`  in  1  short interval expired (yellow/clearance time).
- `TL`  in  1  long interval expired (minimum green time).
- `C`  in  1  side-street car present.
- `MR`, `MY`, `MG`  out  1 each  main-street red / yellow / green lamps.
- `SR`, `SY`, `SG`  out  1 each  side-street red / yellow / green lamps.
- `ST`  out  1  start timer; one-cycle strobe telling the external timer to restart from zero.

## Operation
- States:
  - S0: main green, side red (`MG`, `SR`).
  - S1: main yellow, side red (`MY`, `SR`).
  - S2: main red, side green (`MR`, `SG`).
  - S3: main red, side yellow (`MR`, `SY`).
- Transitions, evaluated each cycle:
  - S0: `TL & C` -> S1; otherwise stay.
  - S1: `TS` -> S2; otherwise stay.
  - S2: `TL | ~C` -> S3; otherwise stay. The side street gets green until its cars clear or the long time expires.
  - S3: `TS` -> S0; otherwise stay.
- `ST` is combinational.
  - It equals 1 in exactly those cycles where the transition condition of the current state is true.
  - So it is high in the cycle before every state change, and low otherwise.
- Lamp outputs are decoded purely from the state register.
  - Exactly one lamp per street is high at all times.
  - Main and side green are never high together.
- Encoding is free (2-bit binary recommended). Any unreachable or illegal encoding returns to S0 on the next edge, with `ST`=0 during that cycle.
- Inputs are assumed synchronous to `Clk`; no internal synchronizers.

## Timing
- State register updates on the rising edge of `Clk`. Lamp outputs change on that edge and are glitch-free relative to the state.
- Latency: condition true in cycle N -> `ST`=1 in cycle N -> new state/lamps visible after edge N+1.
- Reset:
  - `reset`=1 at a rising edge forces S0 regardless of `TS`/`TL`/`C`.
  - Reset values: `MG`=1, `SR`=1, `MR`=`MY`=`SY`=`SG`=0.
  - `ST`=0 whenever `reset`=1; the reset has combinational priority in the `ST` decode.
  - Reset mid-phase (e.g. in S1–S3) abandons the phase immediately at the next edge; no yellow is inserted.
- Simultaneous `TS` and `TL`:
  - In S0, only `TL & C` matters.
  - In S1 and S3, only `TS` matters.
  - In S2, `TL` or `~C` suffices.
- `TS`/`TL` held high continuously: the FSM advances one state per qualifying cycle, with no minimum dwell beyond one cycle.

## Configuration
- `TRAFFIC_ALL_RED_EN` defined:
  - Adds two all-red clearance states:
    - S1 -> AR1 on `TS`, then AR1 -> S2 on `TS`.
    - S3 -> AR2 on `TS`, then AR2 -> S0 on `TS`.
  - In AR1/AR2, `MR`=`SR`=1 and all other lamps are 0.
  - `ST` pulses on entry to each AR state and on exit from it, using the same rule as above.
  - 3-bit state encoding.
- Not defined: four-state machine exactly as in Operation; AR states do not exist.

## Test plan
- Reset: `reset`=1, `TS`=`TL`=`C`=0, one edge -> `MG`=1, `SR`=1, others 0, `ST`=0.
- Yield: from S0, `reset`=0, `TL`=1, `C`=1 -> `ST`=1 in that cycle; after the next edge `MY`=1, `SR`=1, `MG`=0.
- Reset mid-phase: from S1, `reset`=1 with `TS`=`TL`=`C`=0 -> after one edge back to `MG`/`SR`, `ST`=0.
- No car: S0 with `TS`=1, `TL`=1, `C`=0 for 5 cycles -> stays `MG`/`SR`, `ST`=0 throughout.
- Full cycle: drive `C`=1 with `TL`/`TS` pulses -> S0→S1→S2→S3→S0 with one `ST` pulse per transition.
- Side green stays: in S2 with `C`=1 and `TL`=0, `SG` holds. Dropping `C` to 0 -> `ST`=1, then `SY`=1 after the next edge.
- With `TRAFFIC_ALL_RED_EN`: after S1 on `TS`, verify `MR`=`SR`=1 for the AR state, and that `SG` appears only after the next `TS`.
